pinaipple_chip_emulator: RTL and testbench

//  Chip-side responder for the PinAIpple accelerator pad interface. It receives CBL/CBLEN/CSL/CWL,
//  the 2-bit instruction and the row/column addresses driven by pinaipple_system, and returns DATA_out.
//  It emulates the memristor arrays for FPGA bring-up and closed-loop simulation without silicon.
//  It holds NUM_ARR bit-arrays and supports program, read-memory, read-register and majority inference.

---
 rtl/pinaipple_chip_pkg.sv | 27 ++
 rtl/pinaipple_chip_array.sv | 30 +++
 rtl/pinaipple_chip_emulator.sv | 147 ++++++++++++++
 tb/tb_pinaipple_chip_emulator.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pinaipple_chip_pkg.sv
// Shared types and geometry for the PinAIpple chip emulator.
// Pure declarations; no latency or backpressure of its own.
package pinaipple_chip_pkg;

  localparam int NARRAY     = 2;
  localparam int NUM_ARR    = 1 << NARRAY;
  localparam int ROW_W      = 5;
  localparam int COL_W      = 3;
  localparam int NUM_ROWS   = 1 << ROW_W;
  localparam int NUM_COLS   = 1 << COL_W;
  localparam int MAJ_THRESH = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    INSTR_INFER    = 2'b00,
    INSTR_READ_REG = 2'b01,
    INSTR_READ_MEM = 2'b10,
    INSTR_PROG     = 2'b11
  } instr_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } infer_state_e;

endpackage

// File: rtl/pinaipple_chip_array.sv
// One 32x8 emulated memristor array: sync write, registered read, combinational scan tap.
// Latency: 1 clk write and read; no backpressure, contents are deliberately never reset.
module pinaipple_chip_array
  import pinaipple_chip_pkg::*;
(
  input  logic             core_clk,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_col,
  input  logic             wr_dat,
  input  logic             rd_en,
  input  logic [ROW_W-1:0] rd_row,
  input  logic [COL_W-1:0] rd_col,
  output logic             rd_dat,
  input  logic [ROW_W-1:0] tap_row,
  input  logic [COL_W-1:0] tap_col,
  output logic             tap_dat
);

  logic [NUM_COLS-1:0] mem [NUM_ROWS];

  // Read samples the pre-write contents when both hit the same cell.
  always_ff @(posedge core_clk) begin
    if (wr_en) mem[wr_row][wr_col] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_row][rd_col];
  end

  assign tap_dat = mem[tap_row][tap_col];

endmodule

// File: rtl/pinaipple_chip_emulator.sv
// Pad-level responder emulating the memristor arrays: prog, read-mem, read-reg, majority inference.
// Latency: 2 clk pad-to-bit_out on reads, 10 clk scan; no backpressure, pads sampled every clock.
module pinaipple_chip_emulator
  import pinaipple_chip_pkg::*;
(
  input  logic               clk_sys_in,
  input  logic               rst_sys_in,
  input  logic               CBL,
  input  logic               CBLEN,
  input  logic               CSL,
  input  logic               CWL,
  input  logic [1:0]         instructions,
  input  logic [4:0]         addr_col,
  input  logic [4:0]         addr_row,
  output logic [NUM_ARR-1:0] bit_out,
  output logic               busy_o,
  output logic               wr_conflict_o
);

  logic              cbl_s1, csl_s1, cblen_s1, cwl_s1, cwl_s2;
  instr_e            instr_s1;
  logic [NARRAY-1:0] arr_s1;
  logic [COL_W-1:0]  col_s1;
  logic [ROW_W-1:0]  row_s1;

  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      cbl_s1   <= 1'b0;
      csl_s1   <= 1'b0;
      cblen_s1 <= 1'b0;
      cwl_s1   <= 1'b0;
      cwl_s2   <= 1'b0;
      instr_s1 <= INSTR_INFER;
      arr_s1   <= '0;
      col_s1   <= '0;
      row_s1   <= '0;
    end else begin
      cbl_s1   <= CBL;
      csl_s1   <= CSL;
      cblen_s1 <= CBLEN;
      cwl_s1   <= CWL;
      cwl_s2   <= cwl_s1;
      instr_s1 <= instr_e'(instructions);
      arr_s1   <= addr_col[NARRAY-1:0];
      col_s1   <= addr_col[NARRAY +: COL_W];
      row_s1   <= addr_row;
    end
  end

  logic               cwl_rise, prog_strobe, prog_write, scan_start;
  logic [NUM_ARR-1:0] wr_sel, rd_bits, tap_bits;

  assign cwl_rise    = cwl_s1 & ~cwl_s2;
  assign prog_strobe = cwl_rise & cblen_s1 & (instr_s1 == INSTR_PROG);
  assign prog_write  = prog_strobe & (cbl_s1 != csl_s1);
  assign scan_start  = cwl_rise & (instr_s1 == INSTR_INFER);
  assign wr_sel      = NUM_ARR'(1) << arr_s1;

  infer_state_e      state_q, state_d;
  logic [ROW_W-1:0]  row_lat_q;
  logic [COL_W-1:0]  col_cnt_q;
  logic [CNT_W-1:0]  pop_q [NUM_ARR];
  logic [NUM_ARR-1:0] result_q, reg_out_q;
  logic              src_mem_q;

  for (genvar k = 0; k < NUM_ARR; k++) begin : g_arr
    pinaipple_chip_array u_array (
      .core_clk (clk_sys_in),
      .wr_en    (prog_write & wr_sel[k]),
      .wr_row   (row_s1),
      .wr_col   (col_s1),
      .wr_dat   (cbl_s1),
      .rd_en    (instr_s1 == INSTR_READ_MEM),
      .rd_row   (row_s1),
      .rd_col   (col_s1),
      .rd_dat   (rd_bits[k]),
      .tap_row  (row_lat_q),
      .tap_col  (col_cnt_q),
      .tap_dat  (tap_bits[k])
    );
  end

  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (scan_start) state_d = SCAN;
      SCAN: begin
        if (instr_s1 != INSTR_INFER)                 state_d = IDLE;
        else if (col_cnt_q == COL_W'(NUM_COLS - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Busy spans the accepting cycle through DONE, so it falls exactly as the result lands.
  always_comb begin
    busy_o = 1'b0;
    case (state_q)
      IDLE:       busy_o = scan_start;
      SCAN, DONE: busy_o = 1'b1;
      default:    busy_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      row_lat_q     <= '0;
      col_cnt_q     <= '0;
      result_q      <= '0;
      reg_out_q     <= '0;
      src_mem_q     <= 1'b0;
      wr_conflict_o <= 1'b0;
      for (int k = 0; k < NUM_ARR; k++) pop_q[k] <= '0;
    end else begin
      wr_conflict_o <= prog_strobe & (cbl_s1 == csl_s1);
      case (state_q)
        IDLE: if (scan_start) begin
          row_lat_q <= row_s1;
          col_cnt_q <= '0;
          for (int k = 0; k < NUM_ARR; k++) pop_q[k] <= '0;
        end
        SCAN: begin
          col_cnt_q <= col_cnt_q + COL_W'(1);
          for (int k = 0; k < NUM_ARR; k++) pop_q[k] <= pop_q[k] + CNT_W'(tap_bits[k]);
        end
        DONE: for (int k = 0; k < NUM_ARR; k++) result_q[k] <= (pop_q[k] >= CNT_W'(MAJ_THRESH));
        default: ;
      endcase
      // Source select remembers the last read mode so bit_out holds through prog/inference.
      if (instr_s1 == INSTR_READ_MEM) begin
        src_mem_q <= 1'b1;
      end else if (instr_s1 == INSTR_READ_REG) begin
        src_mem_q <= 1'b0;
        reg_out_q <= result_q;
      end
    end
  end

  assign bit_out = src_mem_q ? rd_bits : reg_out_q;

endmodule

// File: tb/tb_pinaipple_chip_emulator.sv
// Directed bench for pinaipple_chip_emulator with a cell model and result scoreboard.
module tb_pinaipple_chip_emulator;
  import pinaipple_chip_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cbl = 1'b0, cblen = 1'b0, csl = 1'b0, cwl = 1'b0;
  logic [1:0] instr = 2'b00;
  logic [4:0] acol = '0, arow = '0;
  logic [3:0] bit_out;
  logic       busy, wrc;

  int         tests = 0;
  int         fails = 0;
  logic [3:0] mdl [32][8];
  logic [3:0] sb [$];
  logic [3:0] res_exp;
  logic [3:0] last_rd;
  int         bcnt;

  always #5 clk = ~clk;

  pinaipple_chip_emulator dut (
    .clk_sys_in    (clk),
    .rst_sys_in    (rst_n),
    .CBL           (cbl),
    .CBLEN         (cblen),
    .CSL           (csl),
    .CWL           (cwl),
    .instructions  (instr),
    .addr_col      (acol),
    .addr_row      (arow),
    .bit_out       (bit_out),
    .busy_o        (busy),
    .wr_conflict_o (wrc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] maj(input int row);
    logic [3:0] r;
    for (int a = 0; a < 4; a++) begin
      int cnt = 0;
      for (int c = 0; c < 8; c++) cnt += int'(mdl[row][c][a]);
      r[a] = (cnt >= 4);
    end
    return r;
  endfunction

  task automatic prog(input int arr, input int row, input int col, input logic b, input logic s, input logic en);
    @(negedge clk);
    instr = INSTR_PROG; arow = row[4:0]; acol = {col[2:0], arr[1:0]};
    cbl = b; csl = s; cblen = en; cwl = 1'b1;
    if (en && (b != s)) mdl[row][col][arr] = b;
    @(negedge clk); cwl = 1'b0;
    @(negedge clk); check("wr_conflict_pulse", 32'(wrc), 32'(en && (b == s)));
    @(negedge clk); check("wr_conflict_end", 32'(wrc), 32'(0));
  endtask

  task automatic read_mem(input int row, input int col);
    sb.push_back(mdl[row][col]);
    @(negedge clk);
    instr = INSTR_READ_MEM; arow = row[4:0]; acol = {col[2:0], 2'b00}; cwl = 1'b0;
    @(negedge clk);
    @(negedge clk);
    last_rd = sb.pop_front();
    check("read_mem", 32'(bit_out), 32'(last_rd));
  endtask

  task automatic read_reg(input logic [3:0] exp);
    sb.push_back(exp);
    @(negedge clk);
    instr = INSTR_READ_REG; cwl = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("read_reg", 32'(bit_out), 32'(sb.pop_front()));
  endtask

  // Column c of the scan is active at the (c+2)-th negedge after the strobe is driven.
  task automatic scan(input int row, input int abort_col, input bit dbl, output int busy_cycles);
    @(negedge clk);
    instr = INSTR_INFER; arow = row[4:0]; cwl = 1'b1;
    busy_cycles = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) cwl = 1'b0;
      if (dbl && i == 3) cwl = 1'b1;
      if (dbl && i == 4) cwl = 1'b0;
      if (i == abort_col + 2) instr = INSTR_READ_MEM;
      if (busy) busy_cycles++;
      else if (i > 1) break;
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 8; c++) mdl[r][c] = 4'b0000;
    res_exp = 4'b0000;

    repeat (3) @(negedge clk);
    check("rst_bit_out", 32'(bit_out), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_wr_conflict", 32'(wrc), 32'(0));
    rst_n = 1'b1;

    // Program row 3 col 5: only array 2 set.
    prog(0, 3, 5, 1'b0, 1'b1, 1'b1);
    prog(1, 3, 5, 1'b0, 1'b1, 1'b1);
    prog(3, 3, 5, 1'b0, 1'b1, 1'b1);
    prog(2, 3, 5, 1'b1, 1'b0, 1'b1);
    read_mem(3, 5);

    // Clear, conflicts in both polarities, and a disabled write.
    prog(2, 3, 5, 1'b0, 1'b1, 1'b1);
    read_mem(3, 5);
    prog(2, 3, 5, 1'b1, 1'b1, 1'b1);
    read_mem(3, 5);
    prog(2, 3, 5, 1'b1, 1'b0, 1'b1);
    read_mem(3, 5);
    prog(2, 3, 5, 1'b0, 1'b0, 1'b1);
    read_mem(3, 5);
    prog(2, 3, 5, 1'b0, 1'b1, 1'b0);
    read_mem(3, 5);

    // Row 7: 8/4/3/0 ones; row 9: 2/3/4/8 ones.
    for (int c = 0; c < 8; c++) begin
      prog(0, 7, c, 1'b1, 1'b0, 1'b1);
      prog(1, 7, c, c < 4, !(c < 4), 1'b1);
      prog(2, 7, c, (c % 2 == 0) && c < 5, !((c % 2 == 0) && c < 5), 1'b1);
      prog(3, 7, c, 1'b0, 1'b1, 1'b1);
    end
    check("hold_during_prog", 32'(bit_out), 32'(last_rd));
    for (int c = 0; c < 8; c++) begin
      prog(0, 9, c, c < 2, !(c < 2), 1'b1);
      prog(1, 9, c, c < 3, !(c < 3), 1'b1);
      prog(2, 9, c, c >= 4, !(c >= 4), 1'b1);
      prog(3, 9, c, 1'b1, 1'b0, 1'b1);
    end
    for (int c = 0; c < 8; c++) read_mem(9, c);
    read_mem(7, 2);

    scan(7, -10, 1'b0, bcnt);
    check("scan_busy_len", 32'(bcnt), 32'(10));
    res_exp = maj(7);
    read_reg(res_exp);

    scan(9, 4, 1'b0, bcnt);
    check("abort_busy_short", 32'(bcnt < 10), 32'(1));
    check("abort_busy_low", 32'(busy), 32'(0));
    read_reg(res_exp);

    scan(9, -10, 1'b1, bcnt);
    check("dbl_busy_len", 32'(bcnt), 32'(10));
    res_exp = maj(9);
    read_reg(res_exp);

    // Reset arrives while the scan is on column 3.
    @(negedge clk);
    instr = INSTR_INFER; arow = 5'd9; cwl = 1'b1;
    @(negedge clk); cwl = 1'b0;
    repeat (4) @(negedge clk);
    check("midscan_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("midscan_rst_bit_out", 32'(bit_out), 32'(0));
    check("midscan_rst_busy", 32'(busy), 32'(0));
    check("midscan_rst_wr_conflict", 32'(wrc), 32'(0));
    @(negedge clk); rst_n = 1'b1;
    res_exp = 4'b0000;
    read_reg(res_exp);

    scan(7, -10, 1'b0, bcnt);
    check("post_rst_busy_len", 32'(bcnt), 32'(10));
    res_exp = maj(7);
    read_reg(res_exp);
    read_mem(3, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
